seq_divider: RTL and testbench

- Multi-cycle unsigned restoring divider; the inverse operation of the multiplier datapath in the arithmetic library.
- One quotient bit per clock, MSB first, computed with a trial subtract built from full-adder cells.
- Start/busy/done handshake toward the host; results held until the next accepted operation.

---
 rtl/div_pkg.sv | 28 ++
 rtl/div_step.sv | 52 +++++
 rtl/seq_divider.sv | 180 ++++++++++++++++++
 tb/tb_seq_divider.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider.
// Contents: default operand width, divider FSM state encoding, counter-width
// helper and a single-bit full-adder cell used by the trial subtractor.
package div_pkg;

  localparam int unsigned DIV_WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2,
    FIX  = 2'd3
  } div_state_e;

  // Smallest r with 2**r >= value.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r++;
    return r;
  endfunction

  // Full-adder cell: returns {carry_out, sum}.
  function automatic logic [1:0] fa(input logic a, input logic b, input logic ci);
    return {(a & b) | (ci & (a ^ b)), a ^ b ^ ci};
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration (purely combinational).
// Shifts the next dividend bit into the partial remainder and trial-subtracts
// the divisor with a WIDTH+1-bit ripple of full adders (inverted divisor,
// carry-in 1). A non-negative difference is kept; otherwise the shifted
// value is restored.
// Ports:
//   p_i       current partial remainder (always < divisor)
//   bit_i     next dividend bit, MSB first
//   divisor_i divisor magnitude
//   p_o       next partial remainder
//   q_o       quotient bit produced by this iteration
module div_step
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] p_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] p_o,
  output logic             q_o
);

  localparam int unsigned TW = WIDTH + 1;

  logic [TW-1:0] shifted;
  logic [TW-1:0] sub_n;
  logic [TW-1:0] trial;

  assign shifted = {p_i, bit_i};
  assign sub_n   = ~{1'b0, divisor_i};

  // Ripple-carry subtract: shifted + ~divisor + 1.
  always_comb begin
    logic       c;
    logic [1:0] cs;
    trial = '0;
    c     = 1'b1;
    for (int i = 0; i < int'(TW); i++) begin
      cs       = fa(shifted[i], sub_n[i], c);
      trial[i] = cs[0];
      c        = cs[1];
    end
  end

  // Since p_i < divisor, the difference fits a signed WIDTH+1-bit value,
  // so its MSB is the sign; a kept remainder is then below the divisor
  // and needs only WIDTH bits.
  assign q_o = ~trial[TW-1];
  assign p_o = q_o ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, MSB first.
// Optional macro SEQ_DIVIDER_SIGNED_EN: two's-complement operands; magnitudes
// are divided and an extra FIX state applies the result signs (quotient
// truncates toward zero, remainder follows the dividend).
// Ports:
//   clk, rst_n           clock (rising edge), async active-low reset
//   start                request, accepted in IDLE or DONE
//   dividend, divisor    operands, captured on accept
//   busy                 operation in progress (CALC, and FIX when signed)
//   done                 one-cycle pulse when results update
//   quotient, remainder  results, held until the next completion
//   div_by_zero          set when the last result had a zero divisor
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = clog2(WIDTH + 1);

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] a_q, a_d;     // dividend shifts out MSB-first, quotient shifts in
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
`endif

  logic             accept;
  logic [WIDTH-1:0] step_p;
  logic             step_q;

  div_step #(.WIDTH(WIDTH)) u_step (
    .p_i       (p_q),
    .bit_i     (a_q[WIDTH-1]),
    .divisor_i (dvs_q),
    .p_o       (step_p),
    .q_o       (step_q)
  );

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    a_d     = a_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
`endif
    accept  = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      IDLE: accept = start;
      CALC: begin
        p_d   = step_p;
        a_d   = {a_q[WIDTH-2:0], step_q};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef SEQ_DIVIDER_SIGNED_EN
          state_d = FIX;
`else
          state_d = DONE;
          quo_d   = {a_q[WIDTH-2:0], step_q};
          rem_d   = step_p;
          dbz_d   = 1'b0;
`endif
        end
      end
`ifdef SEQ_DIVIDER_SIGNED_EN
      FIX: begin
        state_d = DONE;
        quo_d   = qneg_q ? (~a_q + WIDTH'(1)) : a_q;
        rem_d   = rneg_q ? (~p_q + WIDTH'(1)) : p_q;
        dbz_d   = 1'b0;
      end
`endif
      DONE: begin
        state_d = IDLE;
        accept  = start;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      if (divisor == '0) begin
        state_d = DONE;
        quo_d   = '1;
        rem_d   = dividend;
        dbz_d   = 1'b1;
      end else begin
        state_d = CALC;
        p_d     = '0;
        cnt_d   = '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
        a_d     = dividend[WIDTH-1] ? (~dividend + WIDTH'(1)) : dividend;
        dvs_d   = divisor[WIDTH-1] ? (~divisor + WIDTH'(1)) : divisor;
        qneg_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
        rneg_d  = dividend[WIDTH-1];
`else
        a_d     = dividend;
        dvs_d   = divisor;
`endif
      end
    end

`ifdef SEQ_DIVIDER_SIGNED_EN
    busy_d = (state_d == CALC) || (state_d == FIX);
`else
    busy_d = (state_d == CALC);
`endif
    done_d = (state_d == DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      p_q     <= '0;
      a_q     <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      a_q     <= a_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases, exhaustive operand
// sweep and randomized operations against an arithmetic reference model.
module tb_seq_divider;

  localparam int W    = 4;
  localparam int MASK = (1 << W) - 1;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int total = 0;
  int bad   = 0;
  int prev_q = 0, prev_r = 0, prev_dz = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: plain integer division on the operand values.
  function automatic void model(input int n, input int d, output int q,
                                output int r, output int dz, output int lat,
                                output int bcyc);
`ifdef SEQ_DIVIDER_SIGNED_EN
    int sn, sd;
    sn = (n >= (1 << (W - 1))) ? n - (1 << W) : n;
    sd = (d >= (1 << (W - 1))) ? d - (1 << W) : d;
    if (sd == 0) begin
      q = MASK; r = n; dz = 1; lat = 1; bcyc = 0;
    end else begin
      q = (sn / sd) & MASK; r = (sn % sd) & MASK; dz = 0; lat = W + 2; bcyc = W + 1;
    end
`else
    if (d == 0) begin
      q = MASK; r = n; dz = 1; lat = 1; bcyc = 0;
    end else begin
      q = n / d; r = n % d; dz = 0; lat = W + 1; bcyc = W;
    end
`endif
  endfunction

  // Issue one operation. b2b: caller is in the DONE cycle and starts at once.
  // inj: during busy keep requesting 2/1 (must be ignored); otherwise random.
  task automatic do_op(input int n, input int d, input bit b2b, input bit inj);
    int eq, er, edz, elat, ebusy, cyc, bcnt;
    model(n, d, eq, er, edz, elat, ebusy);
    if (!b2b) begin
      @(negedge clk);
      check("done_low_after_pulse", int'(done), 0);
    end
    start    = 1'b1;
    dividend = W'(n);
    divisor  = W'(d);
    @(negedge clk);
    cyc  = 1;
    bcnt = 0;
    while (!done && cyc < 40) begin
      if (busy) begin
        bcnt++;
        check("q_hold", int'(quotient), prev_q);
        check("r_hold", int'(remainder), prev_r);
        start    = inj ? 1'b1 : 1'($urandom_range(0, 1));
        dividend = inj ? W'(2) : W'($urandom);
        divisor  = inj ? W'(1) : W'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check($sformatf("latency %0d/%0d", n, d), cyc, elat);
    check($sformatf("busy_cycles %0d/%0d", n, d), bcnt, ebusy);
    check($sformatf("quotient %0d/%0d", n, d), int'(quotient), eq);
    check($sformatf("remainder %0d/%0d", n, d), int'(remainder), er);
    check($sformatf("div_by_zero %0d/%0d", n, d), int'(div_by_zero), edz);
    prev_q  = eq;
    prev_r  = er;
    prev_dz = edz;
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_quotient", int'(quotient), 0);
    check("rst_remainder", int'(remainder), 0);
    check("rst_dbz", int'(div_by_zero), 0);
    rst_n = 1'b1;

    // Directed cases.
    do_op(13, 4, 1'b0, 1'b0);
    do_op(7, 0, 1'b0, 1'b0);
    do_op(15, 1, 1'b0, 1'b0);
    do_op(3, 9, 1'b0, 1'b0);
    do_op(13, 4, 1'b0, 1'b1);
    do_op(9, 2, 1'b1, 1'b0);
    do_op(5, 0, 1'b1, 1'b0);
    do_op(6, 3, 1'b1, 1'b0);
`ifdef SEQ_DIVIDER_SIGNED_EN
    do_op(9, 2, 1'b0, 1'b0);     // -7 / 2
    do_op(8, 15, 1'b0, 1'b0);    // -8 / -1
`endif

    // Reset during the second CALC cycle aborts with no done pulse.
    @(negedge clk);
    start    = 1'b1;
    dividend = W'(13);
    divisor  = W'(4);
    @(negedge clk);
    start = 1'b0;
    check("abort_busy_before", int'(busy), 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_quotient", int'(quotient), 0);
    check("abort_remainder", int'(remainder), 0);
    check("abort_dbz", int'(div_by_zero), 0);
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", int'(done), 0);
    end
    rst_n   = 1'b1;
    prev_q  = 0;
    prev_r  = 0;
    prev_dz = 0;
    do_op(11, 3, 1'b0, 1'b0);

    // Exhaustive operand sweep.
    for (int n = 0; n <= MASK; n++)
      for (int d = 0; d <= MASK; d++)
        do_op(n, d, 1'b0, 1'b0);

    // Randomized operations with random back-to-back starts.
    for (int k = 0; k < 60; k++)
      do_op(int'($urandom_range(0, MASK)), int'($urandom_range(0, MASK)),
            1'($urandom_range(0, 1)), 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
